// File: rtl/accumulator_processor.sv
// Accumulator-memory PE: fetches operand pairs, adds with saturation, sends each sum back until a fetched zero.
// Latency: op issues 1 cycle after gnt is sampled, ADD_LATENCY cycles per add; backpressure: gnt low parks op at NOP, state held.
module accumulator_processor #(
    parameter int unsigned ADD_LATENCY = 2,
    parameter logic [1:0]  OP_NOP      = 2'b00,
    parameter logic [1:0]  OP_FETCH    = 2'b01,
    parameter logic [1:0]  OP_SEND     = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        gnt,
    input  logic        signal,
    input  logic [31:0] read,
    output logic        req,
    output logic [1:0]  op,
    output logic [31:0] write,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] add_count
);
    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, ADD, SEND, GAP, DONE} state_t;

    localparam logic [3:0] ADD_LAST = 4'(ADD_LATENCY - 1);

    state_t      state_q, state_d, ret_q, ret_d;
    logic [31:0] a_q, a_d, b_q, b_d, write_q, write_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] add_count_q, add_count_d;
    logic        lone_q, lone_d, issued_q, issued_d;
    logic        req_q, req_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [32:0] sum;
    logic        waiting, accept;
    logic [1:0]  bus_op;

    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign waiting = state_q inside {FETCH_A, FETCH_B, SEND};
    // A transaction is outstanding once its op has been driven, even if gnt later pulled it back to NOP.
    assign accept  = waiting && signal && (issued_q || (op_q != OP_NOP));
    assign bus_op  = (state_q == SEND) ? OP_SEND : OP_FETCH;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        a_d         = a_q;
        b_d         = b_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        lone_d      = lone_q;
        ovf_d       = ovf_q;
        add_count_d = add_count_q;
        issued_d    = 1'b0;
        op_d        = OP_NOP;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH_A;
                    lone_d      = 1'b0;
                    ovf_d       = 1'b0;
                    add_count_d = '0;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = FETCH_A;
                    lone_d  = 1'b0;
                end
            end
            FETCH_A: begin
                if (accept) begin
                    a_d     = read;
                    state_d = GAP;
                    ret_d   = (read != '0) ? FETCH_B : DONE;
                end
            end
            FETCH_B: begin
                if (accept) begin
                    b_d = read;
                    if (read != '0) begin
                        state_d = ADD;
                        cnt_d   = ADD_LAST;
                    end else begin
                        // Memory held a single value: hand it back unchanged and finish.
                        state_d = SEND;
                        write_d = a_q;
                        lone_d  = 1'b1;
                    end
                end
            end
            ADD: begin
                if (cnt_q == '0) begin
                    state_d = SEND;
                    write_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
                    ovf_d   = ovf_q | sum[32];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SEND: begin
                if (accept) begin
                    add_count_d = add_count_q + 16'd1;
                    state_d     = GAP;
                    ret_d       = lone_q ? DONE : FETCH_A;
                end
            end
            GAP:     state_d = ret_q;
            default: state_d = IDLE;
        endcase
        if (waiting && !accept) begin
            issued_d = issued_q || (op_q != OP_NOP);
            if (gnt) op_d = bus_op;
        end
        req_d  = state_d inside {FETCH_A, FETCH_B, SEND};
        busy_d = !(state_d inside {IDLE, DONE});
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            write_q     <= '0;
            cnt_q       <= '0;
            op_q        <= OP_NOP;
            add_count_q <= '0;
            lone_q      <= 1'b0;
            issued_q    <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            a_q         <= a_d;
            b_q         <= b_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            add_count_q <= add_count_d;
            lone_q      <= lone_d;
            issued_q    <= issued_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign req       = req_q;
    assign op        = op_q;
    assign write     = write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign add_count = add_count_q;
endmodule

// File: tb/tb_accumulator_processor.sv
// Bench for accumulator_processor: a queue-backed accumulator memory with random latency and grant,
// checked against a reference that reduces the operand list pairwise.
module tb_accumulator_processor;
    localparam int         LAT   = 3;
    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] SEND  = 2'b10;

    logic        clk = 1'b0;
    logic        reset, start, gnt, signal;
    logic [31:0] read;
    logic        req, busy, done, overflow;
    logic [1:0]  op;
    logic [31:0] write;
    logic [15:0] add_count;

    accumulator_processor #(.ADD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .gnt(gnt), .signal(signal), .read(read),
        .req(req), .op(op), .write(write), .busy(busy), .done(done),
        .overflow(overflow), .add_count(add_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] prog_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] sent_q[$];
    int          n_fetch;
    int          m_lat_max;
    bit          gnt_rand;
    bit          m_pend;
    int          m_cnt;
    logic [1:0]  m_kind;
    bit          sig_prev, gnt_prev;

    // Memory semantics: fetch pops the oldest value (0 when empty), send appends.
    function automatic void ref_model(output logic [31:0] last, output int sends,
                                      output bit ovf, output int rest_n);
        logic [31:0] q[$];
        logic [31:0] a, b;
        logic [32:0] s;
        q = prog_q; last = 32'h0; sends = 0; ovf = 1'b0;
        while (q.size() >= 2) begin
            a = q.pop_front();
            b = q.pop_front();
            s = {1'b0, a} + {1'b0, b};
            last = s[32] ? 32'hFFFF_FFFF : s[31:0];
            ovf = ovf | s[32];
            sends++;
            q.push_back(last);
        end
        if (q.size() == 1) begin
            last = q[0];
            sends++;
        end
        rest_n = q.size();
    endfunction

    // One clock: sample what the DUT is about to see, then play the memory after the edge.
    task automatic step();
        sig_prev = signal;
        gnt_prev = gnt;
        @(posedge clk);
        #1;
        signal = 1'b0;
        read = $urandom;
        if (m_pend) begin
            if (m_cnt <= 1) begin
                m_pend = 1'b0;
                signal = 1'b1;
                if (m_kind == FETCH) begin
                    n_fetch++;
                    if (mem_q.size() > 0) read = mem_q.pop_front();
                    else read = 32'h0;
                end else begin
                    mem_q.push_back(write);
                    sent_q.push_back(write);
                end
            end else begin
                m_cnt--;
            end
        end else if (op != NOP) begin
            m_pend = 1'b1;
            m_cnt  = $urandom_range(1, m_lat_max);
            m_kind = op;
        end
        if (gnt_rand) gnt = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; signal = 1'b0; gnt = 1'b1;
        gnt_rand = 1'b0; m_pend = 1'b0; m_lat_max = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        mem_q.delete(); sent_q.delete(); n_fetch = 0;
    endtask

    task automatic run_prog(input bit chk_bus, input int budget);
        bit fin = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < budget && !fin; i++) begin
            step();
            if (chk_bus && sig_prev) begin
                n_vec++;
                if (op !== NOP) begin n_err++; $display("FAIL op_after_signal: op=%0d required %0d", op, NOP); end
            end
            if (chk_bus && op !== NOP) begin
                n_vec++;
                if (gnt_prev !== 1'b1) begin n_err++; $display("FAIL op_without_gnt: op=%0d gnt=%0b required gnt=1", op, gnt_prev); end
            end
            fin = (done === 1'b1);
        end
        n_vec++;
        if (!fin) begin n_err++; $display("FAIL run_timeout: done=%0b after %0d cycles, required 1", done, budget); end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (req !== 1'b0)       begin n_err++; $display("FAIL rst_req: %0b req 0", req); end
        n_vec++; if (op !== NOP)         begin n_err++; $display("FAIL rst_op: %0d req 0", op); end
        n_vec++; if (write !== 32'h0)    begin n_err++; $display("FAIL rst_write: %h req 0", write); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy: %0b req 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done: %0b req 0", done); end
        n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL rst_ovf: %0b req 0", overflow); end
        n_vec++; if (add_count !== 16'h0) begin n_err++; $display("FAIL rst_cnt: %0d req 0", add_count); end
    endtask

    task automatic test_pair();
        int cap = -1;
        bit seen1 = 1'b0, lat_chk = 1'b0, fin = 1'b0;
        do_reset();
        prog_q = '{32'd3, 32'd5}; mem_q = prog_q;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            step();
            if (sig_prev && n_fetch == 2 && sent_q.size() == 0) cap = i;
            if (cap >= 0 && !lat_chk && req === 1'b1) begin
                lat_chk = 1'b1; n_vec++;
                if (i - cap != LAT) begin n_err++; $display("FAIL add_latency: %0d cycles req %0d", i - cap, LAT); end
            end
            if (sig_prev && sent_q.size() == 1 && !seen1) begin
                seen1 = 1'b1; n_vec++;
                if (add_count !== 16'd1) begin n_err++; $display("FAIL pair_cnt1: %0d req 1", add_count); end
            end
            fin = (done === 1'b1);
        end
        n_vec++; if (!fin) begin n_err++; $display("FAIL pair_timeout: done=%0b req 1", done); end
        n_vec++;
        if (sent_q.size() !== 2 || sent_q[0] !== 32'd8 || sent_q[1] !== 32'd8) begin
            n_err++; $display("FAIL pair_sends: %0d sends, required 8 then 8", sent_q.size());
        end
        n_vec++; if (add_count !== 16'd2) begin n_err++; $display("FAIL pair_cnt: %0d req 2", add_count); end
        n_vec++; if (write !== 32'd8)     begin n_err++; $display("FAIL pair_write: %0d req 8", write); end
        n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL pair_busy: %0b req 0", busy); end
    endtask

    task automatic test_lone();
        do_reset();
        prog_q = '{32'd7}; mem_q = prog_q;
        run_prog(1'b1, 400);
        n_vec++;
        if (sent_q.size() !== 1 || sent_q[0] !== 32'd7) begin n_err++; $display("FAIL lone_send: %0d sends, required one of 7", sent_q.size()); end
        n_vec++; if (add_count !== 16'd1) begin n_err++; $display("FAIL lone_cnt: %0d req 1", add_count); end
        n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL lone_ovf: %0b req 0", overflow); end
        // A stray strobe in DONE must change nothing.
        signal = 1'b1; read = 32'h55;
        step();
        n_vec++; if (done !== 1'b1 || req !== 1'b0 || op !== NOP) begin n_err++; $display("FAIL stray_signal: done=%0b req=%0b op=%0d required 1,0,0", done, req, op); end
        n_vec++; if (write !== 32'd7) begin n_err++; $display("FAIL stray_write: %0d req 7", write); end
    endtask

    task automatic test_empty();
        do_reset();
        prog_q.delete(); mem_q.delete();
        run_prog(1'b1, 200);
        n_vec++; if (add_count !== 16'd0) begin n_err++; $display("FAIL empty_cnt: %0d req 0", add_count); end
        n_vec++; if (write !== 32'd0 || sent_q.size() !== 0) begin n_err++; $display("FAIL empty_write: %h, %0d sends, required 0", write, sent_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        prog_q = '{32'hFFFF_FFF0, 32'h20}; mem_q = prog_q;
        run_prog(1'b1, 400);
        n_vec++;
        if (sent_q.size() < 1 || sent_q[0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_write: %0d sends, required first FFFFFFFF", sent_q.size()); end
        repeat (3) step();
        n_vec++; if (overflow !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL sat_sticky: ovf=%0b done=%0b required 1,1", overflow, done); end
        n_vec++; if (add_count !== 16'd2) begin n_err++; $display("FAIL sat_cnt: %0d req 2", add_count); end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        prog_q = '{32'd3, 32'd5}; mem_q = prog_q;
        gnt = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d]: %0b req 1", i, req); end
            n_vec++; if (op !== NOP)   begin n_err++; $display("FAIL stall_op[%0d]: %0d req 0", i, op); end
        end
        gnt = 1'b1;
        step();
        n_vec++; if (op !== FETCH) begin n_err++; $display("FAIL stall_issue: %0d req %0d", op, FETCH); end
        for (int i = 0; i < 400 && done !== 1'b1; i++) step();
        n_vec++; if (write !== 32'd8 || done !== 1'b1) begin n_err++; $display("FAIL stall_result: write=%0d done=%0b required 8,1", write, done); end
    endtask

    task automatic test_reset_mid_add();
        bit hit = 1'b0;
        logic [31:0] e_last; int e_sends, e_rest; bit e_ovf;
        do_reset();
        prog_q = '{32'd3, 32'd5, 32'd9}; mem_q = prog_q;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step();
            hit = sig_prev && n_fetch == 4 && sent_q.size() == 1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL midadd_reach: second add not reached, required within 400 cycles"); end
        step();
        n_vec++; if (busy !== 1'b1 || write !== 32'd8 || add_count !== 16'd1) begin n_err++; $display("FAIL midadd_pre: busy=%0b write=%0d cnt=%0d required 1,8,1", busy, write, add_count); end
        reset = 1'b0; step(); reset = 1'b1;
        n_vec++;
        if (req !== 1'b0 || op !== NOP || write !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || add_count !== 16'h0) begin
            n_err++; $display("FAIL midadd_reset: req=%0b op=%0d write=%h busy=%0b done=%0b ovf=%0b cnt=%0d required all 0", req, op, write, busy, done, overflow, add_count);
        end
        prog_q = '{32'd4, 32'd6}; mem_q = prog_q; sent_q.delete(); n_fetch = 0; m_pend = 1'b0;
        ref_model(e_last, e_sends, e_ovf, e_rest);
        run_prog(1'b1, 400);
        n_vec++; if (write !== e_last || add_count !== 16'(e_sends)) begin n_err++; $display("FAIL midadd_restart: write=%0d cnt=%0d required %0d,%0d", write, add_count, e_last, e_sends); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_last; int e_sends, e_rest; bit e_ovf;
        for (int run = 0; run < 3; run++) begin
            do_reset();
            m_lat_max = run + 2;
            gnt_rand = 1'b1;
            prog_q.delete();
            for (int k = 0; k < ((run == 2) ? int'($urandom_range(2, 12)) : 10); k++)
                prog_q.push_back((run == 0) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'h1));
            mem_q = prog_q;
            ref_model(e_last, e_sends, e_ovf, e_rest);
            run_prog(1'b1, 8000);
            n_vec++; if (write !== e_last) begin n_err++; $display("FAIL b2b_write[%0d]: %h req %h", run, write, e_last); end
            n_vec++; if (add_count !== 16'(e_sends)) begin n_err++; $display("FAIL b2b_cnt[%0d]: %0d req %0d", run, add_count, e_sends); end
            n_vec++; if (overflow !== e_ovf) begin n_err++; $display("FAIL b2b_ovf[%0d]: %0b req %0b", run, overflow, e_ovf); end
            n_vec++;
            if (mem_q.size() !== e_rest || (e_rest == 1 && mem_q[0] !== e_last)) begin
                n_err++; $display("FAIL b2b_mem[%0d]: %0d values left, required %0d holding %h", run, mem_q.size(), e_rest, e_last);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; gnt = 1'b1; signal = 1'b0; read = 32'h0;
        test_reset();
        test_pair();
        test_lone();
        test_empty();
        test_overflow();
        test_gnt_stall();
        test_reset_mid_add();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
